// File: rtl/smart_mac_array_ctrl.sv
// smart_mac_array_ctrl: sequences one tile job through LOAD, COMPUTE and
// DRAIN on an ROWS x COLS smart-bus MAC array. Every output is a flop whose
// next value is derived from the next state, so phase outputs change on
// the same edge as the state.
module smart_mac_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 8,
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_k,
  input  logic [ROWS-1:0]  cfg_row_smart,
  input  logic [COLS-1:0]  cfg_col_smart,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             stat_bit,
  output logic             fsm_op2_select,
  output logic             fsm_out_select,
  output logic [ROWS-1:0]  select_left_in_smart,
  output logic [COLS-1:0]  select_top_in_smart,
  output logic             in_valid,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_row_idx
);

  // Phase counter must hold cfg_k + ROWS + COLS - 2 for the largest cfg_k
  // without wrapping, so it gets headroom beyond CNT_W.
  localparam int SKEW_W = $clog2(ROWS + COLS + 1);
  localparam int PH_W   = ((CNT_W > SKEW_W) ? CNT_W : SKEW_W) + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [ROWS-1:0]   row_q, row_d;
  logic [COLS-1:0]   col_q, col_d;

  logic              busy_d, done_d, err_d, stat_bit_d, op2_d, out_sel_d;
  logic              in_valid_d, out_valid_d;
  logic [ROWS-1:0]   left_d;
  logic [COLS-1:0]   top_d;
  logic [IDX_W-1:0]  out_row_idx_d;

  logic [PH_W-1:0]   edge_last;
  logic [PH_W-1:0]   compute_last;

  assign edge_last    = PH_W'(ROWS - 1);
  assign compute_last = PH_W'(k_q) + PH_W'(ROWS + COLS - 2) - PH_W'(1);

  // Next-state, phase counter, configuration latch and next output values.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_k != '0) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            k_d     = cfg_k;
            row_d   = cfg_row_smart;
            col_d   = cfg_col_smart;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (cnt_q == edge_last) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt_q == compute_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == edge_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort only cancels a job in flight; in IDLE a concurrent start wins.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    stat_bit_d    = (state_d == S_LOAD);
    op2_d         = (state_d == S_COMPUTE);
    out_sel_d     = (state_d == S_DRAIN);
    out_valid_d   = (state_d == S_DRAIN);
    // Feeders run through LOAD and the first cfg_k COMPUTE cycles only.
    in_valid_d    = (state_d == S_LOAD) ||
                    ((state_d == S_COMPUTE) && (cnt_d < PH_W'(k_d)));
    out_row_idx_d = (state_d == S_DRAIN) ? cnt_d[IDX_W-1:0] : '0;
    left_d        = busy_d ? row_d : '0;
    top_d         = busy_d ? col_d : '0;
  end

  // State, counter, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q              <= S_IDLE;
      cnt_q                <= '0;
      k_q                  <= '0;
      row_q                <= '0;
      col_q                <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      err                  <= 1'b0;
      stat_bit             <= 1'b0;
      fsm_op2_select       <= 1'b0;
      fsm_out_select       <= 1'b0;
      select_left_in_smart <= '0;
      select_top_in_smart  <= '0;
      in_valid             <= 1'b0;
      out_valid            <= 1'b0;
      out_row_idx          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      k_q                  <= k_d;
      row_q                <= row_d;
      col_q                <= col_d;
      busy                 <= busy_d;
      done                 <= done_d;
      err                  <= err_d;
      stat_bit             <= stat_bit_d;
      fsm_op2_select       <= op2_d;
      fsm_out_select       <= out_sel_d;
      select_left_in_smart <= left_d;
      select_top_in_smart  <= top_d;
      in_valid             <= in_valid_d;
      out_valid            <= out_valid_d;
      out_row_idx          <= out_row_idx_d;
    end
  end

endmodule

// File: tb/tb_smart_mac_array_ctrl.sv
// Bench for smart_mac_array_ctrl: expected per-cycle output records are
// pushed when stimulus is driven and compared as the DUT produces them.
module tb_smart_mac_array_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       stat;
    logic       op2;
    logic       out_sel;
    logic       in_valid;
    logic       out_valid;
    logic [1:0] idx;
    logic [3:0] left;
    logic [3:0] top;
  } rec_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_k;
  logic [ROWS-1:0]  cfg_row_smart;
  logic [COLS-1:0]  cfg_col_smart;
  logic             busy, done, err, stat_bit, fsm_op2_select, fsm_out_select;
  logic [ROWS-1:0]  select_left_in_smart;
  logic [COLS-1:0]  select_top_in_smart;
  logic             in_valid, out_valid;
  logic [1:0]       out_row_idx;

  rec_t obs;
  rec_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  smart_mac_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .cfg_k                (cfg_k),
    .cfg_row_smart        (cfg_row_smart),
    .cfg_col_smart        (cfg_col_smart),
    .busy                 (busy),
    .done                 (done),
    .err                  (err),
    .stat_bit             (stat_bit),
    .fsm_op2_select       (fsm_op2_select),
    .fsm_out_select       (fsm_out_select),
    .select_left_in_smart (select_left_in_smart),
    .select_top_in_smart  (select_top_in_smart),
    .in_valid             (in_valid),
    .out_valid            (out_valid),
    .out_row_idx          (out_row_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = '{busy, done, err, stat_bit, fsm_op2_select, fsm_out_select,
                 in_valid, out_valid, out_row_idx,
                 select_left_in_smart, select_top_in_smart};

  task automatic check(input string tag, input rec_t got, input rec_t exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Expected outputs in cycle t (t=1 is the cycle after the accepted start).
  function automatic rec_t job_rec(input int t, input int k,
                                   input logic [3:0] r, input logic [3:0] c);
    rec_t e;
    int   lc;
    e  = '0;
    lc = k + ROWS + COLS - 2;
    if (t <= ROWS) begin
      e.stat = 1'b1; e.in_valid = 1'b1;
    end else if (t <= ROWS + lc) begin
      e.op2 = 1'b1; e.in_valid = ((t - ROWS) <= k);
    end else if (t <= 2 * ROWS + lc) begin
      e.out_sel = 1'b1; e.out_valid = 1'b1;
      e.idx = 2'(t - ROWS - lc - 1);
    end else begin
      e.done = 1'b1;
    end
    e.busy = 1'b1; e.left = r; e.top = c;
    return e;
  endfunction

  function automatic int job_len(input int k);
    return 1 + 3 * ROWS + COLS - 2 + k;
  endfunction

  task automatic push_job(input int k, input int upto,
                          input logic [3:0] r, input logic [3:0] c);
    for (int t = 1; t <= upto; t++) sb_q.push_back(job_rec(t, k, r, c));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(rec_t'(0));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", rec_t'(sb_q.size()), rec_t'(0));
    sb_q.delete();
  endtask

  // Scoreboard consumer: one expected record per cycle while any are queued.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) check("cycle", obs, sb_q.pop_front());
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_k = '0; cfg_row_smart = '0; cfg_col_smart = '0;
    repeat (2) @(negedge clk);
    check("reset", obs, rec_t'(0));
    rst = 1'b1;
    push_idle(1);
    wait_drain();

    // Nominal job k=8, cfg inputs changed mid-job, start+cfg_k=0 while busy.
    @(negedge clk);
    cfg_k = 8'd8; cfg_row_smart = 4'b0101; cfg_col_smart = 4'b1000;
    push_job(8, job_len(8), 4'b0101, 4'b1000);
    push_idle(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_k = 8'd3; cfg_row_smart = 4'b1111; cfg_col_smart = 4'b1111;
    repeat (9) @(negedge clk);
    start = 1'b1; cfg_k = 8'd0;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Rejected start.
    @(negedge clk);
    cfg_k = 8'd0; cfg_row_smart = 4'b0011; cfg_col_smart = 4'b0110;
    start = 1'b1;
    sb_q.push_back(rec_t'{err: 1'b1, default: '0});
    push_idle(2);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Abort on the 3rd COMPUTE cycle, then start+abort together in IDLE.
    @(negedge clk);
    cfg_k = 8'd8; cfg_row_smart = 4'b1010; cfg_col_smart = 4'b0001;
    push_job(8, ROWS + 3, 4'b1010, 4'b0001);
    push_idle(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    cfg_k = 8'd1; cfg_row_smart = 4'b0110; cfg_col_smart = 4'b1001;
    push_job(1, job_len(1), 4'b0110, 4'b1001);
    push_idle(1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    wait_drain();

    // Asynchronous reset mid-DRAIN, then a maximum-length job.
    @(negedge clk);
    cfg_k = 8'd2; cfg_row_smart = 4'b1100; cfg_col_smart = 4'b0011;
    push_job(2, 14, 4'b1100, 4'b0011);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst", obs, rec_t'(0));
    @(negedge clk);
    check("rst_held", obs, rec_t'(0));
    rst = 1'b1;
    push_idle(1);
    @(negedge clk);
    cfg_k = 8'd255; cfg_row_smart = 4'b1001; cfg_col_smart = 4'b0110;
    push_job(255, job_len(255), 4'b1001, 4'b0110);
    push_idle(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // start held high: second job accepted only in the IDLE cycle after DONE.
    @(negedge clk);
    cfg_k = 8'd1; cfg_row_smart = 4'b0111; cfg_col_smart = 4'b1110;
    push_job(1, job_len(1), 4'b0111, 4'b1110);
    push_idle(1);
    push_job(1, job_len(1), 4'b0111, 4'b1110);
    push_idle(2);
    start = 1'b1;
    repeat (job_len(1) + 2) @(negedge clk);
    start = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/smart_mac_array_ctrl.md
# smart_mac_array_ctrl

Sequencer for an ROWS x COLS array of smart-bus MAC cells. It accepts one tile job through a start/done handshake and drives the shared per-array MAC control lines (`stat_bit`, `fsm_op2_select`, `fsm_out_select`) through load, compute and drain phases. It also drives the per-row and per-column smart-bus input selects, and paces the operand feeders and result collector. It sits between the tile scheduler and the MAC array. All outputs are registered.

## Interface
- ROWS, 4, array rows; also the length of the LOAD and DRAIN phases (>=1).
- COLS, 4, array columns (>=1).
- CNT_W, 8, width of cfg_k.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  job request, sampled only in IDLE.
- abort  input  1  synchronous cancel, any non-IDLE state.
- cfg_k  input  CNT_W  reduction length (operand vectors per job), latched on accepted start.
- cfg_row_smart  input  ROWS  per-row smart-bus bypass mask, latched on accepted start.
- cfg_col_smart  input  COLS  per-column smart-bus bypass mask, latched on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.
- err  output  1  one-cycle pulse on rejected start (cfg_k == 0).
- stat_bit  output  1  to all MACs; high in LOAD.
- fsm_op2_select  output  1  to all MACs; high in COMPUTE.
- fsm_out_select  output  1  to all MACs; high in DRAIN.
- select_left_in_smart  output  ROWS  bit r to every MAC in row r.
- select_top_in_smart  output  COLS  bit c to every MAC in column c.
- in_valid  output  1  operand feeders advance one word.
- out_valid  output  1  result collector captures the array bottom edge.
- out_row_idx  output  clog2(ROWS) (min 1)  drain row index, valid with out_valid.

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE. Encoding is free.
- IDLE, start=1, cfg_k!=0:
  - Latch cfg_k, cfg_row_smart and cfg_col_smart.
  - Go to LOAD.
- IDLE, start=1, cfg_k==0:
  - Stay in IDLE.
  - Pulse err next cycle.
  - No latch.
- LOAD:
  - Lasts exactly ROWS cycles.
  - stat_bit=1, in_valid=1 (stationary operands shifted in).
  - Then go to COMPUTE.
- COMPUTE:
  - Lasts exactly cfg_k + ROWS + COLS - 2 cycles, covering the array skew.
  - fsm_op2_select=1 throughout.
  - in_valid=1 only for the first cfg_k cycles, 0 for the skew tail.
  - Then go to DRAIN.
- DRAIN:
  - Lasts exactly ROWS cycles.
  - fsm_out_select=1, out_valid=1.
  - out_row_idx counts 0..ROWS-1, one per cycle.
  - Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. start is not sampled in DONE.
- Smart selects:
  - select_left_in_smart equals the latched row mask and select_top_in_smart equals the latched column mask in all non-IDLE states.
  - Both are all-zero in IDLE.
  - The masks cannot change mid-job.
- Phase counter: CNT_W+1 bits minimum. cfg_k = 2^CNT_W - 1 must not wrap.
- start while busy: ignored, no err, the job in flight is unaffected.
- abort:
  - Any non-IDLE state goes to IDLE at the next edge.
  - No done pulse.
  - All control outputs go to 0 the same edge.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Reset (rst=0):
  - Immediately forces IDLE.
  - All outputs are 0, including the masks and out_row_idx.
  - Latched configuration is cleared to 0.
  - Mid-job reset discards the job without a done pulse.

## Timing
- Accepted start at edge E0: LOAD outputs visible after E0. The job occupies cycles 1..ROWS.
- COMPUTE occupies the next cfg_k+ROWS+COLS-2 cycles. DRAIN occupies the next ROWS cycles. done follows in the next cycle.
- start-to-done latency = 1 + 3*ROWS + COLS - 2 + cfg_k cycles. With ROWS=COLS=4 and cfg_k=8, done is high in cycle 23.
- At most one of stat_bit, fsm_op2_select and fsm_out_select is high in any cycle.
- Phase changes are gapless: there are no idle cycles between LOAD, COMPUTE and DRAIN.
- busy rises the cycle after the accepted start and falls the cycle after DONE.
- Earliest next accepted start is the cycle after DONE, i.e. once the controller is back in IDLE.
- err rises one cycle after the rejected start.

## Test plan
- ROWS=COLS=4, cfg_k=8, start 1 cycle -> stat_bit high 4 cycles, fsm_op2_select high 14 cycles (in_valid high first 8), fsm_out_select high 4 cycles with out_row_idx 0,1,2,3, done pulse at cycle 23, busy high cycles 1..23.
- cfg_row_smart=4'b0101, cfg_col_smart=4'b1000 with start, then change cfg inputs mid-job -> selects hold 0101/1000 through DONE, 0 in IDLE.
- start with cfg_k=0 -> err pulse next cycle, busy stays 0, no phase outputs.
- abort on 3rd COMPUTE cycle, then start 2 cycles later with cfg_k=1 -> immediate return to IDLE, no done, new job completes with done at cycle 16 after its start.
- rst driven low asynchronously mid-DRAIN -> all outputs 0 before the next clk edge. After rst release, start with cfg_k=255 -> COMPUTE lasts 261 cycles with no counter wrap.
- start held high continuously for two jobs -> second job accepted only in the IDLE cycle after DONE, with no overlap of phase outputs.
